// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Shared types and constants for the car lane generator.
//   coord_t        : 10-bit unsigned screen coordinate
//   lane_state_e   : lane FSM state (IDLE / RUN)
//   slot_state_t   : per-slot registered state (active, x, acc, tile, frame)
//   boxes_overlap  : strict axis-aligned box overlap test (edge touch = miss)
// -----------------------------------------------------------------------------
package car_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_RUN  = 1'b1
  } lane_state_e;

  typedef struct packed {
    logic       active;
    coord_t     x;
    logic [1:0] acc;    // sub-pixel accumulator, quarter pixels
    logic [3:0] tile;   // animation tile within the car type
    logic [3:0] frame;  // frames spent on the current tile
  } slot_state_t;

  localparam int TILES_PER_ANIM_DEF  = 4;
  localparam int FRAMES_PER_TILE_DEF = 5;

  // Player foot box sits 30 px below the player origin and is 16x1.
  localparam coord_t PLAYER_OFS_Y = 10'd30;
  localparam coord_t PLAYER_BOX_W = 10'd16;
  localparam coord_t PLAYER_BOX_H = 10'd1;
  // Car hit box is the bottom 16 rows of the sprite.
  localparam coord_t CAR_BOX_H    = 10'd16;

  // Strict overlap on both axes; all sums wrap at 10 bits like the rest of
  // the coordinate arithmetic.
  function automatic logic boxes_overlap(
    input coord_t ax, input coord_t ay, input coord_t aw, input coord_t ah,
    input coord_t bx, input coord_t by, input coord_t bw, input coord_t bh
  );
    coord_t a_r, a_b, b_r, b_b;
    a_r = ax + aw;
    a_b = ay + ah;
    b_r = bx + bw;
    b_b = by + bh;
    return (ax < b_r) && (bx < a_r) && (ay < b_b) && (by < a_b);
  endfunction

endpackage

// File: rtl/car_lane_if.sv
// -----------------------------------------------------------------------------
// car_lane_if
// Groups the lane control, draw and collision signals of car_lane.
// There is no valid/ready handshake on this bus: every input is sampled on
// each rising frame clock edge, and every output is combinational from the
// registered slot state plus the current draw/player inputs.
//   master : game logic / renderer side (drives controls, reads results)
//   slave  : car_lane side
// -----------------------------------------------------------------------------
interface car_lane_if
  import car_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SPEED_W     = 5,
  parameter int GAP_W       = 8
);
  logic                      LaneEnable;
  logic                      FaceLeft;
  logic [1:0]                Type;
  logic [SPEED_W-1:0]        Speed;
  logic [GAP_W-1:0]          SpawnGap;
  logic [9:0]                SpawnX;
  logic [9:0]                SpawnY;
  logic [9:0]                DrawX;
  logic [9:0]                DrawY;
  logic [NUM_PLAYERS*10-1:0] PlayerX;
  logic [NUM_PLAYERS*10-1:0] PlayerY;
  logic [NUM_PLAYERS*5-1:0]  PlayerHbOffset;
  logic [NUM_PLAYERS-1:0]    PlayerHit;
  logic                      CarPixel;
  logic [3:0]                Tile;
  logic [5:0]                PixelX;
  logic [4:0]                PixelY;
  logic [3:0]                ActiveCount;
  lane_state_e               DbgState;

  modport master (
    output LaneEnable, FaceLeft, Type, Speed, SpawnGap, SpawnX, SpawnY,
           DrawX, DrawY, PlayerX, PlayerY, PlayerHbOffset,
    input  PlayerHit, CarPixel, Tile, PixelX, PixelY, ActiveCount, DbgState
  );

  modport slave (
    input  LaneEnable, FaceLeft, Type, Speed, SpawnGap, SpawnX, SpawnY,
           DrawX, DrawY, PlayerX, PlayerY, PlayerHbOffset,
    output PlayerHit, CarPixel, Tile, PixelX, PixelY, ActiveCount, DbgState
  );
endinterface

// File: rtl/car_slot.sv
// -----------------------------------------------------------------------------
// car_slot
// One car slot: registered state, quarter-pixel movement, off-screen despawn,
// tile animation, plus the combinational draw and collision terms.
//   clk_i, rst_ni   : frame clock, async active-low reset
//   flush_i         : deactivate the slot this edge
//   spawn_i         : (re)activate at spawn_x_i this edge; wins over despawn
//   face_left_i     : motion toward decreasing X
//   speed_i         : quarter pixels per frame
//   type_i          : car sprite type
//   spawn_x_i/y_i   : spawn X, lane top Y
//   draw_x_i/y_i    : current render pixel
//   player_*_i      : packed player positions and hitbox X offsets
//   active_o        : slot holds a car
//   free_o          : slot is empty or empties on this edge
//   hit_o           : draw pixel lies inside this car
//   tile_o, pixel_x_o : sprite tile and column for this car
//   player_hit_o    : per-player overlap with this car
// -----------------------------------------------------------------------------
module car_slot
  import car_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int SPEED_W         = 5,
  parameter int CAR_W           = 48,
  parameter int CAR_H           = 26,
  parameter int MIN_X           = 100,
  parameter int MAX_X           = 739,
  parameter int TILES_PER_ANIM  = TILES_PER_ANIM_DEF,
  parameter int FRAMES_PER_TILE = FRAMES_PER_TILE_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      spawn_i,
  input  logic                      face_left_i,
  input  logic [SPEED_W-1:0]        speed_i,
  input  logic [1:0]                type_i,
  input  coord_t                    spawn_x_i,
  input  coord_t                    spawn_y_i,
  input  coord_t                    draw_x_i,
  input  coord_t                    draw_y_i,
  input  logic [NUM_PLAYERS*10-1:0] player_x_i,
  input  logic [NUM_PLAYERS*10-1:0] player_y_i,
  input  logic [NUM_PLAYERS*5-1:0]  player_hb_i,
  output logic                      active_o,
  output logic                      free_o,
  output logic                      hit_o,
  output logic [3:0]                tile_o,
  output logic [5:0]                pixel_x_o,
  output logic [NUM_PLAYERS-1:0]    player_hit_o
);

  localparam coord_t     CAR_W_C = coord_t'(CAR_W);
  localparam coord_t     CAR_H_C = coord_t'(CAR_H);
  localparam coord_t     MIN_X_C = coord_t'(MIN_X);
  localparam coord_t     MAX_X_C = coord_t'(MAX_X);
  localparam logic [3:0] TPA_C   = 4'(TILES_PER_ANIM);
  localparam logic [3:0] FPT_C   = 4'(FRAMES_PER_TILE);

  slot_state_t        st_q, st_d;
  coord_t             x_far;
  coord_t             y_far;
  coord_t             car_box_y;
  logic               despawn;
  logic [SPEED_W:0]   sum;
  coord_t             step;

  assign x_far     = st_q.x + CAR_W_C;
  assign y_far     = spawn_y_i + CAR_H_C;
  assign car_box_y = spawn_y_i + CAR_H_C - CAR_BOX_H;

  // Despawn looks at the position before this frame's move.
  assign despawn = st_q.active &&
                   (face_left_i ? (x_far < MIN_X_C) : (st_q.x >= MAX_X_C));

  assign sum  = (SPEED_W+1)'(st_q.acc) + (SPEED_W+1)'(speed_i);
  assign step = coord_t'(sum >> 2);

  always_comb begin
    st_d = st_q;
    if (flush_i) begin
      st_d = '0;
    end else if (spawn_i) begin
      st_d.active = 1'b1;
      st_d.x      = spawn_x_i;
      st_d.acc    = 2'd0;
      st_d.tile   = 4'd0;
      st_d.frame  = 4'd0;
    end else if (st_q.active) begin
      if (despawn) begin
        st_d.active = 1'b0;
      end else begin
        st_d.acc = sum[1:0];
        st_d.x   = face_left_i ? (st_q.x - step) : (st_q.x + step);
        if (st_q.frame == FPT_C - 4'd1) begin
          st_d.frame = 4'd0;
          st_d.tile  = (st_q.tile == TPA_C - 4'd1) ? 4'd0 : st_q.tile + 4'd1;
        end else begin
          st_d.frame = st_q.frame + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign active_o = st_q.active;
  assign free_o   = !st_q.active || despawn;

  assign hit_o = st_q.active &&
                 (st_q.x <= draw_x_i) && (draw_x_i < x_far) &&
                 (spawn_y_i <= draw_y_i) && (draw_y_i < y_far);

  assign tile_o = 4'(type_i) * TPA_C + st_q.tile;

  // Sprites are stored left-facing; right-facing cars read columns mirrored.
  assign pixel_x_o = face_left_i ? 6'(draw_x_i - st_q.x)
                                 : 6'(CAR_W_C - 10'd1 - (draw_x_i - st_q.x));

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    coord_t px, py;
    assign px = player_x_i[10*p +: 10] + coord_t'(player_hb_i[5*p +: 5]);
    assign py = player_y_i[10*p +: 10] + PLAYER_OFS_Y;
    assign player_hit_o[p] = st_q.active &&
        boxes_overlap(px, py, PLAYER_BOX_W, PLAYER_BOX_H,
                      st_q.x, car_box_y, CAR_W_C, CAR_BOX_H);
  end

endmodule

// File: rtl/car_lane.sv
// -----------------------------------------------------------------------------
// car_lane
// Pooled traffic generator for one road lane. Spawns cars at a programmable
// frame gap into the lowest free slot, moves and animates them, and merges
// their draw and collision terms.
//   FrameClk : frame-rate clock, all state updates on its rising edge
//   ResetN   : asynchronous active-low reset
//   bus      : car_lane_if.slave (lane controls, draw position, players in;
//              CarPixel/Tile/PixelX/PixelY, PlayerHit, ActiveCount,
//              DbgState out)
// Build option: define CAR_LANE_GAP_JITTER_EN to add an 8-bit LFSR that
// stretches each spawn gap by 0..7 frames.
// -----------------------------------------------------------------------------
module car_lane
  import car_pkg::*;
#(
  parameter int NUM_CARS        = 4,
  parameter int NUM_PLAYERS     = 2,
  parameter int SPEED_W         = 5,
  parameter int GAP_W           = 8,
  parameter int CAR_W           = 48,
  parameter int CAR_H           = 26,
  parameter int MIN_X           = 100,
  parameter int MAX_X           = 739,
  parameter int TILES_PER_ANIM  = TILES_PER_ANIM_DEF,
  parameter int FRAMES_PER_TILE = FRAMES_PER_TILE_DEF
) (
  input logic       FrameClk,
  input logic       ResetN,
  car_lane_if.slave bus
);

  lane_state_e                          state_q, state_d;
  logic [GAP_W-1:0]                     gap_q, gap_d;
  logic [GAP_W-1:0]                     gap_target;
  logic                                 flush;
  logic [NUM_CARS-1:0]                  spawn_sel;
  logic [NUM_CARS-1:0]                  first_free;
  logic [NUM_CARS-1:0]                  slot_free;
  logic [NUM_CARS-1:0]                  slot_active;
  logic [NUM_CARS-1:0]                  slot_hit;
  logic [NUM_CARS-1:0][3:0]             slot_tile;
  logic [NUM_CARS-1:0][5:0]             slot_pixx;
  logic [NUM_CARS-1:0][NUM_PLAYERS-1:0] slot_phit;

  // Lowest-index free slot, one-hot.
  always_comb begin
    logic found;
    found      = 1'b0;
    first_free = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (slot_free[i] && !found) begin
        first_free[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Lane FSM and spawn scheduling. The gap counter parks at the target while
  // the pool is full so the spawn fires on the first frame a slot frees.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    spawn_sel = '0;
    flush     = 1'b0;
    case (state_q)
      LANE_IDLE: begin
        if (bus.LaneEnable) begin
          state_d      = LANE_RUN;
          spawn_sel[0] = 1'b1;
          gap_d        = '0;
        end else begin
          flush = 1'b1;
        end
      end
      LANE_RUN: begin
        if (!bus.LaneEnable) begin
          state_d = LANE_IDLE;
          flush   = 1'b1;
          gap_d   = '0;
        end else if (gap_q >= gap_target) begin
          if (|slot_free) begin
            spawn_sel = first_free;
            gap_d     = '0;
          end else begin
            gap_d = gap_target;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = LANE_IDLE;
        flush   = 1'b1;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= LANE_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

`ifdef CAR_LANE_GAP_JITTER_EN
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       jit_q, jit_d;
  logic [GAP_W:0]   tgt_sum;

  // Taps 8,6,5,4: maximal-length sequence.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    jit_d  = (|spawn_sel) ? lfsr_q[2:0] : jit_q;
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      lfsr_q <= 8'hA5;
      jit_q  <= 3'd0;
    end else begin
      lfsr_q <= lfsr_d;
      jit_q  <= jit_d;
    end
  end

  assign tgt_sum    = {1'b0, bus.SpawnGap} + {{(GAP_W-2){1'b0}}, jit_q};
  assign gap_target = tgt_sum[GAP_W] ? {GAP_W{1'b1}} : tgt_sum[GAP_W-1:0];
`else
  assign gap_target = bus.SpawnGap;
`endif

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_slot
    car_slot #(
      .NUM_PLAYERS    (NUM_PLAYERS),
      .SPEED_W        (SPEED_W),
      .CAR_W          (CAR_W),
      .CAR_H          (CAR_H),
      .MIN_X          (MIN_X),
      .MAX_X          (MAX_X),
      .TILES_PER_ANIM (TILES_PER_ANIM),
      .FRAMES_PER_TILE(FRAMES_PER_TILE)
    ) u_slot (
      .clk_i       (FrameClk),
      .rst_ni      (ResetN),
      .flush_i     (flush),
      .spawn_i     (spawn_sel[i]),
      .face_left_i (bus.FaceLeft),
      .speed_i     (bus.Speed),
      .type_i      (bus.Type),
      .spawn_x_i   (bus.SpawnX),
      .spawn_y_i   (bus.SpawnY),
      .draw_x_i    (bus.DrawX),
      .draw_y_i    (bus.DrawY),
      .player_x_i  (bus.PlayerX),
      .player_y_i  (bus.PlayerY),
      .player_hb_i (bus.PlayerHbOffset),
      .active_o    (slot_active[i]),
      .free_o      (slot_free[i]),
      .hit_o       (slot_hit[i]),
      .tile_o      (slot_tile[i]),
      .pixel_x_o   (slot_pixx[i]),
      .player_hit_o(slot_phit[i])
    );
  end

  logic                   car_pixel;
  logic [3:0]             tile_out;
  logic [5:0]             pixel_x;
  logic [4:0]             pixel_y;
  logic [3:0]             active_cnt;
  logic [NUM_PLAYERS-1:0] player_hit;

  // Walk from the top slot down so the lowest-index hit is the last writer.
  always_comb begin
    car_pixel = 1'b0;
    tile_out  = 4'd0;
    pixel_x   = 6'd0;
    pixel_y   = 5'd0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        car_pixel = 1'b1;
        tile_out  = slot_tile[i];
        pixel_x   = slot_pixx[i];
        pixel_y   = 5'(bus.DrawY - bus.SpawnY);
      end
    end
  end

  always_comb begin
    active_cnt = 4'd0;
    player_hit = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      active_cnt = active_cnt + {3'd0, slot_active[i]};
      player_hit = player_hit | slot_phit[i];
    end
  end

  assign bus.CarPixel    = car_pixel;
  assign bus.Tile        = tile_out;
  assign bus.PixelX      = pixel_x;
  assign bus.PixelY      = pixel_y;
  assign bus.ActiveCount = active_cnt;
  assign bus.PlayerHit   = player_hit & {NUM_PLAYERS{bus.LaneEnable}};
  assign bus.DbgState    = state_q;

endmodule

// File: tb/tb_car_lane.sv
module tb_car_lane;
  import car_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  car_lane_if #(.NUM_PLAYERS(2), .SPEED_W(5), .GAP_W(8)) bus ();
  car_lane_if #(.NUM_PLAYERS(2), .SPEED_W(5), .GAP_W(8)) bus2 ();

  car_lane #(.NUM_CARS(4)) u_dut (
    .FrameClk(clk),
    .ResetN  (rst_n),
    .bus     (bus)
  );

  car_lane #(.NUM_CARS(2)) u_dut2 (
    .FrameClk(clk),
    .ResetN  (rst_n),
    .bus     (bus2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    bus.LaneEnable = 1'b0; bus.FaceLeft = 1'b0; bus.Type = 2'd0;
    bus.Speed = 5'd0; bus.SpawnGap = 8'd0; bus.SpawnX = 10'd0;
    bus.SpawnY = 10'd0; bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    bus.PlayerX = 20'd0; bus.PlayerY = 20'd0; bus.PlayerHbOffset = 10'd0;
    bus2.LaneEnable = 1'b0; bus2.FaceLeft = 1'b0; bus2.Type = 2'd0;
    bus2.Speed = 5'd0; bus2.SpawnGap = 8'd0; bus2.SpawnX = 10'd0;
    bus2.SpawnY = 10'd0; bus2.DrawX = 10'd0; bus2.DrawY = 10'd0;
    bus2.PlayerX = 20'd0; bus2.PlayerY = 20'd0; bus2.PlayerHbOffset = 10'd0;

    // Reset state
    #3;
    check("rst_active_count", 32'(bus.ActiveCount), 0);
    check("rst_car_pixel",    32'(bus.CarPixel), 0);
    check("rst_player_hit",   32'(bus.PlayerHit), 0);
    check("rst_tile",         32'(bus.Tile), 0);
    check("rst_pixel_x",      32'(bus.PixelX), 0);
    check("rst_pixel_y",      32'(bus.PixelY), 0);
    check("rst_state",        32'(bus.DbgState), 32'(LANE_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Pool full: 2 slots, gap 3, stationary cars
    bus2.LaneEnable = 1'b1; bus2.SpawnGap = 8'd3; bus2.SpawnX = 10'd200;
    bus2.SpawnY = 10'd100;
    tick();
    check("pool_e0_count", 32'(bus2.ActiveCount), 1);
    check("pool_e0_state", 32'(bus2.DbgState), 32'(LANE_RUN));
    tick(); tick(); tick();
    check("pool_e3_count", 32'(bus2.ActiveCount), 1);
    tick();
    check("pool_e4_count", 32'(bus2.ActiveCount), 2);
    for (int i = 0; i < 5; i++) tick();
    check("pool_e9_count", 32'(bus2.ActiveCount), 2);
    bus2.LaneEnable = 1'b0;
    tick();
    check("pool_flush_count", 32'(bus2.ActiveCount), 0);
    check("pool_flush_state", 32'(bus2.DbgState), 32'(LANE_IDLE));

    // Sub-pixel motion: 1.25 px/frame to the right from X=200
    bus.FaceLeft = 1'b0; bus.SpawnX = 10'd200; bus.SpawnY = 10'd100;
    bus.Speed = 5'd5; bus.SpawnGap = 8'd255; bus.Type = 2'd2;
    bus.DrawX = 10'd230; bus.DrawY = 10'd110; bus.LaneEnable = 1'b1;
    tick();
    check("mv_e0_pixx",  32'(bus.PixelX), 17);
    check("mv_e0_pix",   32'(bus.CarPixel), 1);
    check("mv_e0_pixy",  32'(bus.PixelY), 10);
    check("mv_e0_tile",  32'(bus.Tile), 8);
    check("mv_e0_count", 32'(bus.ActiveCount), 1);
    tick();
    check("mv_e1_pixx", 32'(bus.PixelX), 18);
    tick();
    check("mv_e2_pixx", 32'(bus.PixelX), 19);
    tick();
    check("mv_e3_pixx", 32'(bus.PixelX), 20);
    tick();
    check("mv_e4_pixx", 32'(bus.PixelX), 22);
    check("mv_e4_tile", 32'(bus.Tile), 8);
    tick();
    check("mv_e5_pixx", 32'(bus.PixelX), 23);
    check("mv_e5_tile", 32'(bus.Tile), 9);

    // Draw priority and mirroring: cars at 300 and 320
    bus.LaneEnable = 1'b0;
    tick();
    check("dp_flush_count", 32'(bus.ActiveCount), 0);
    bus.LaneEnable = 1'b1; bus.SpawnX = 10'd300; bus.Speed = 5'd0;
    bus.SpawnGap = 8'd0; bus.Type = 2'd1;
    tick();
    bus.SpawnX = 10'd320;
    tick();
    bus.SpawnGap = 8'd255;
    check("dp_count", 32'(bus.ActiveCount), 2);
    bus.DrawX = 10'd330; bus.DrawY = 10'd110;
    #1;
    check("dp_pix",  32'(bus.CarPixel), 1);
    check("dp_pixx", 32'(bus.PixelX), 17);
    check("dp_tile", 32'(bus.Tile), 4);
    check("dp_pixy", 32'(bus.PixelY), 10);
    bus.DrawX = 10'd360;
    #1;
    check("dp_slot1_pixx", 32'(bus.PixelX), 7);
    bus.FaceLeft = 1'b1; bus.DrawX = 10'd330;
    #1;
    check("dp_left_pixx", 32'(bus.PixelX), 30);
    bus.FaceLeft = 1'b0;
    bus.DrawY = 10'd99;
    #1;
    check("dp_above_pix", 32'(bus.CarPixel), 0);
    bus.DrawY = 10'd110;

    // Collision edges against car at 300 (car box y 110..125)
    bus.PlayerX = {10'd280, 10'd284};
    bus.PlayerY = {10'd95, 10'd80};
    bus.PlayerHbOffset = {5'd5, 5'd0};
    #1;
    check("col_x_edges", 32'(bus.PlayerHit), 2);
    bus.PlayerX = {10'd280, 10'd285};
    bus.PlayerY = {10'd96, 10'd80};
    #1;
    check("col_y_edges", 32'(bus.PlayerHit), 1);
    bus.LaneEnable = 1'b0;
    #1;
    check("col_gated", 32'(bus.PlayerHit), 0);
    bus.LaneEnable = 1'b1;

    // Asynchronous reset with three cars active
    bus.SpawnGap = 8'd0; bus.SpawnX = 10'd500;
    tick();
    check("ar_count_before", 32'(bus.ActiveCount), 3);
    check("ar_hit_before",   32'(bus.PlayerHit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count",     32'(bus.ActiveCount), 0);
    check("ar_pix",       32'(bus.CarPixel), 0);
    check("ar_playerhit", 32'(bus.PlayerHit), 0);
    check("ar_state",     32'(bus.DbgState), 32'(LANE_IDLE));
    bus.LaneEnable = 1'b0;
    bus.PlayerX = 20'd0; bus.PlayerY = 20'd0; bus.PlayerHbOffset = 10'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Despawn at the left edge: 4 px/frame from X=52
    bus.FaceLeft = 1'b1; bus.Speed = 5'd16; bus.SpawnX = 10'd52;
    bus.SpawnGap = 8'd255; bus.DrawX = 10'd60; bus.DrawY = 10'd110;
    bus.LaneEnable = 1'b1;
    tick();
    check("ds_a_pixx",  32'(bus.PixelX), 8);
    check("ds_a_count", 32'(bus.ActiveCount), 1);
    tick();
    check("ds_b_pixx",  32'(bus.PixelX), 12);
    check("ds_b_count", 32'(bus.ActiveCount), 1);
    tick();
    check("ds_c_count", 32'(bus.ActiveCount), 0);
    check("ds_c_pix",   32'(bus.CarPixel), 0);
    check("ds_c_state", 32'(bus.DbgState), 32'(LANE_RUN));

    // Free and spawn on the same edge
    bus.LaneEnable = 1'b0;
    tick();
    bus.LaneEnable = 1'b1; bus.SpawnGap = 8'd1;
    tick();
    check("ru_a_pixx", 32'(bus.PixelX), 8);
    tick();
    check("ru_b_pixx",  32'(bus.PixelX), 12);
    check("ru_b_count", 32'(bus.ActiveCount), 1);
    tick();
    check("ru_c_pixx",  32'(bus.PixelX), 8);
    check("ru_c_count", 32'(bus.ActiveCount), 1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
